// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and writeback.
// Memory states wait for mem_ready and give up after WAIT_TIMEOUT not-ready cycles.
// Control outputs are Moore-decoded from the state register and held at 0 while in reset.
module multicycle_control #(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned TMO_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRtypeWb  = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam bit             TmoEn  = (WAIT_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TmoVal = TMO_W'(WAIT_TIMEOUT);

  state_e             r_state;
  logic [5:0]         r_op;
  logic [TMO_W-1:0]   r_wait_cnt;
  logic               r_instr_done;
  logic               r_illegal_op;
  logic               r_bus_error;

  state_e             w_state_next;
  logic [5:0]         w_op_next;
  logic [TMO_W-1:0]   w_wait_next;
  logic               w_done_next;
  logic               w_illegal_next;
  logic               w_buserr_next;
  logic               w_waiting;
  logic               w_timeout;

  // States that stall on the memory handshake.
  assign w_waiting = (r_state == StFetch) || (r_state == StMemRead) || (r_state == StMemWrite);

  // mem_ready wins over an expiring counter: the access completes instead of aborting.
  assign w_timeout = TmoEn && w_waiting && !mem_ready && (r_wait_cnt == TmoVal);

  // Next-state, opcode latch and retirement/error pulse decode.
  always_comb begin
    w_state_next   = r_state;
    w_op_next      = r_op;
    w_done_next    = 1'b0;
    w_illegal_next = 1'b0;
    w_buserr_next  = 1'b0;
    case (r_state)
      StFetch: begin
        if (mem_ready) begin
          w_state_next = StDecode;
        end else if (w_timeout) begin
          // Retry the fetch from scratch; the counter clears below.
          w_state_next  = StFetch;
          w_buserr_next = 1'b1;
        end
      end
      StDecode: begin
        w_op_next = opcode;
        case (opcode)
          OpLw, OpSw: w_state_next = StMemAddr;
          OpRtype:    w_state_next = StExecute;
          OpBeq:      w_state_next = StBranch;
          OpJ:        w_state_next = StJump;
          default: begin
            w_state_next   = StFetch;
            w_illegal_next = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        if (r_op == OpLw) begin
          w_state_next = StMemRead;
        end else if (r_op == OpSw) begin
          w_state_next = StMemWrite;
        end else begin
          w_state_next = StFetch;
        end
      end
      StMemRead: begin
        if (mem_ready) begin
          w_state_next = StMemWb;
        end else if (w_timeout) begin
          // Abandon the load; writeback never happens.
          w_state_next  = StFetch;
          w_buserr_next = 1'b1;
        end
      end
      StMemWb: begin
        w_state_next = StFetch;
        w_done_next  = 1'b1;
      end
      StMemWrite: begin
        if (mem_ready) begin
          w_state_next = StFetch;
          w_done_next  = 1'b1;
        end else if (w_timeout) begin
          w_state_next  = StFetch;
          w_buserr_next = 1'b1;
        end
      end
      StExecute: begin
        w_state_next = StRtypeWb;
      end
      StRtypeWb, StBranch, StJump: begin
        w_state_next = StFetch;
        w_done_next  = 1'b1;
      end
      default: begin
        w_state_next = StFetch;
      end
    endcase
  end

  // Wait counter: counts consecutive stalled cycles, clears on ready, timeout or state change.
  always_comb begin
    w_wait_next = '0;
    if (w_waiting && !mem_ready && !w_timeout && (w_state_next == r_state)) begin
      w_wait_next = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + TMO_W'(1);
    end
  end

  // State, opcode latch, wait counter and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StFetch;
      r_op         <= '0;
      r_wait_cnt   <= '0;
      r_instr_done <= 1'b0;
      r_illegal_op <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_op         <= w_op_next;
      r_wait_cnt   <= w_wait_next;
      r_instr_done <= w_done_next;
      r_illegal_op <= w_illegal_next;
      r_bus_error  <= w_buserr_next;
    end
  end

  // Moore control decode; rst_n gates everything so reset drops strobes without waiting a clock.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (rst_n) begin
      case (r_state)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          // PC+4 and IR load only commit once the instruction word is actually there.
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        StDecode: begin
          ALUSrcB = 2'b11;
        end
        StMemAddr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRead: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        StMemWrite: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StExecute: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        StRtypeWb: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign instr_done = r_instr_done;
  assign illegal_op = r_illegal_op;
  assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a per-cycle expected-vector scoreboard.
module tb_multicycle_control;

  localparam int unsigned Tmo = 4;

  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SWB = 4'd4;
  localparam logic [3:0] SMW = 4'd5, SEX = 4'd6, SRW = 4'd7, SBR = 4'd8, SJ = 4'd9;
  // Pulse field: {instr_done, illegal_op, bus_error}.
  localparam logic [2:0] PN = 3'b000, PD = 3'b100, PI = 3'b010, PB = 3'b001;

  localparam logic [5:0] OpRt = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpBad = 6'b111111;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegDst, RegWrite, ALUSrcA, instr_done, illegal_op, bus_error;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  logic [22:0] obs;
  logic [22:0] exp_q[$];
  string       tag_q[$];
  int          vectors;
  int          miscompares;

  multicycle_control #(
    .WAIT_TIMEOUT(Tmo),
    .TMO_W       (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .bus_error  (bus_error)
  );

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, instr_done, illegal_op,
                bus_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control table per state, straight from the state/output list.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa} = '0;
    asb  = 2'b00;
    aop  = 2'b00;
    psrc = 2'b00;
    case (st)
      4'd0: begin mrd = 1'b1; asb = 2'b01; pcw = mr; irw = mr; end
      4'd1: begin asb = 2'b11; end
      4'd2: begin asa = 1'b1; asb = 2'b10; end
      4'd3: begin mrd = 1'b1; iord = 1'b1; end
      4'd4: begin m2r = 1'b1; rw = 1'b1; end
      4'd5: begin mwr = 1'b1; iord = 1'b1; end
      4'd6: begin asa = 1'b1; aop = 2'b10; end
      4'd7: begin rdst = 1'b1; rw = 1'b1; end
      4'd8: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      4'd9: begin pcw = 1'b1; psrc = 2'b10; end
      default: begin end
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, asb, aop, psrc};
  endfunction

  task automatic push(input logic [22:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    logic [22:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // Called just after a rising edge: drive mem_ready, expect state st with pulses pl this cycle.
  task automatic cyc(input logic mr, input logic [3:0] st, input logic [2:0] pl,
                     input string tag);
    mem_ready = mr;
    push({exp_ctrl(st, mr), st, pl}, tag);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    mem_ready   = 1'b1;
    opcode      = OpLw;
    #2;
    push(23'h0, "reset_outputs_zero");
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lw, no stalls: 0,1,2,3,4 then FETCH with instr_done.
    cyc(1'b1, SF,  PN, "lw_fetch");
    cyc(1'b1, SD,  PN, "lw_decode");
    cyc(1'b1, SMA, PN, "lw_memaddr");
    cyc(1'b1, SMR, PN, "lw_memread");
    cyc(1'b1, SWB, PN, "lw_memwb");
    opcode = OpRt;
    cyc(1'b1, SF,  PD, "rt_fetch_lw_done");
    cyc(1'b1, SD,  PN, "rt_decode");
    cyc(1'b1, SEX, PN, "rt_execute");
    cyc(1'b1, SRW, PN, "rt_wb");
    opcode = OpBeq;
    cyc(1'b1, SF,  PD, "beq_fetch_rt_done");
    cyc(1'b1, SD,  PN, "beq_decode");
    cyc(1'b1, SBR, PN, "beq_branch");
    opcode = OpJ;
    cyc(1'b1, SF,  PD, "j_fetch_beq_done");
    cyc(1'b1, SD,  PN, "j_decode");
    cyc(1'b1, SJ,  PN, "j_jump");

    // sw with three stalled cycles in MEM_WRITE: below the timeout, no bus_error.
    opcode = OpSw;
    cyc(1'b1, SF,  PD, "sw_fetch_j_done");
    cyc(1'b1, SD,  PN, "sw_decode");
    cyc(1'b1, SMA, PN, "sw_memaddr");
    cyc(1'b0, SMW, PN, "sw_wait1");
    cyc(1'b0, SMW, PN, "sw_wait2");
    cyc(1'b0, SMW, PN, "sw_wait3");
    cyc(1'b1, SMW, PN, "sw_complete");

    // Illegal opcode, then a FETCH stall that runs into the timeout and is retried.
    opcode = OpBad;
    cyc(1'b1, SF,  PD, "ill_fetch_sw_done");
    cyc(1'b1, SD,  PN, "ill_decode");
    cyc(1'b0, SF,  PI, "ill_pulse_fetch_stall1");
    for (int i = 2; i <= int'(Tmo) + 1; i++) begin
      cyc(1'b0, SF, PN, $sformatf("fetch_stall%0d", i));
    end
    opcode = OpLw;
    cyc(1'b1, SF,  PB, "fetch_timeout_retry");

    // lw stuck in MEM_READ: Tmo stalled cycles counted, aborted on the next, no RegWrite.
    cyc(1'b1, SD,  PN, "lwto_decode");
    cyc(1'b1, SMA, PN, "lwto_memaddr");
    for (int i = 1; i <= int'(Tmo) + 1; i++) begin
      cyc(1'b0, SMR, PN, $sformatf("lwto_wait%0d", i));
    end
    opcode = OpRt;
    cyc(1'b1, SF,  PB, "lwto_bus_error");

    // R-type reset mid-EXECUTE: outputs drop at once, restart in FETCH with no pulse.
    cyc(1'b1, SD,  PN, "rtrst_decode");
    mem_ready = 1'b1;
    push({exp_ctrl(SEX, 1'b1), SEX, PN}, "rtrst_execute");
    #2;
    check();
    rst_n = 1'b0;
    #1;
    push(23'h0, "rtrst_outputs_zero");
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, SF,  PN, "rtrst_post_fetch");
    cyc(1'b1, SD,  PN, "rtrst2_decode");
    cyc(1'b1, SEX, PN, "rtrst2_execute");
    cyc(1'b1, SRW, PN, "rtrst2_wb");
    cyc(1'b1, SF,  PD, "rtrst2_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
